// File: rtl/parity_pkg.sv
// Shared types and constants for the parity serial receiver.
// Used by parity_serial_rx and parity_err_counter.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        DONE
    } rx_state_t;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/parity_err_counter.sv
// Saturating parity error counter with synchronous clear.
// Instantiated by parity_serial_rx only under PARITY_ERR_COUNT_EN.
module parity_err_counter
    import parity_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/parity_serial_rx.sv
// Serial word receiver: LSB-first payload followed by a parity bit.
// Define PARITY_ERR_COUNT_EN to add the err_count port and counter.
module parity_serial_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 serial_in,
    input  logic                 err_clr,
    output logic [DATA_W-1:0]    data_out,
    output logic                 word_valid,
    output logic                 parity_err,
`ifdef PARITY_ERR_COUNT_EN
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
`else
    output logic                 busy
`endif
);

    localparam int   CNT_W = $clog2(DATA_W);
    localparam logic ODD   = (ODD_PARITY != 0);

    rx_state_t        state;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            par_acc    <= 1'b0;
            data_out   <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= DATA;
                        bit_cnt    <= '0;
                        par_acc    <= 1'b0;
                        data_out   <= '0;
                        parity_err <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        data_out[bit_cnt] <= serial_in;
                        par_acc           <= par_acc ^ serial_in;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        parity_err <= par_acc ^ serial_in ^ ODD;
                        word_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    parity_err_counter u_err_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (word_valid & parity_err),
        .clr   (err_clr),
        .count (err_count)
    );
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed self-checking bench for parity_serial_rx (DATA_W=32, even).
// Counter scenarios build only when PARITY_ERR_COUNT_EN is defined.
module tb_parity_serial_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        serial_in = 1'b0;
    logic        err_clr = 1'b0;
    logic [31:0] data_out;
    logic        word_valid;
    logic        parity_err;
    logic        busy;
`ifdef PARITY_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int errors = 0;
    int checks = 0;

    logic        wv_seen;
    logic [31:0] dout;
    logic        perr;
    int          cyc;
    bit          early;

    always #5 clk = ~clk;

    parity_serial_rx #(.DATA_W(32), .ODD_PARITY(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .word_valid (word_valid),
        .parity_err (parity_err),
`ifdef PARITY_ERR_COUNT_EN
        .busy       (busy),
        .err_count  (err_count)
`else
        .busy       (busy)
`endif
    );

    // Drives one word from IDLE; returns at the negedge of the DONE cycle.
    task automatic run_word(input logic [31:0] w, input logic p,
                            input bit gaps, input int start_at,
                            input bit bv_with_start);
        early = 0;
        start = 1'b1;
        bit_valid = bv_with_start;
        serial_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b0;
        cyc = 1;
        for (int i = 0; i < 32; i++) begin
            bit_valid = 1'b1;
            serial_in = w[i];
            start = (i == start_at);
            @(negedge clk);
            cyc++;
            start = 1'b0;
            bit_valid = 1'b0;
            if (word_valid) early = 1;
            if (gaps && (i % 4 == 0)) begin
                for (int g = 0; g < 2; g++) begin
                    serial_in = ~w[i];
                    @(negedge clk);
                    cyc++;
                    if (word_valid) early = 1;
                end
            end
        end
        bit_valid = 1'b1;
        serial_in = p;
        @(negedge clk);
        cyc++;
        bit_valid = 1'b0;
        serial_in = 1'b0;
        wv_seen = word_valid;
        dout = data_out;
        perr = parity_err;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", data_out);
        end
        checks++;
        if ({word_valid, parity_err, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {word_valid, parity_err, busy});
        end
`ifdef PARITY_ERR_COUNT_EN
        checks++;
        if (err_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_errcnt: got %h want 0", err_count);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_word;
        run_word(32'hA5A5_0001, 1'b1, 0, -1, 0);
        checks++;
        if (wv_seen !== 1'b1) begin
            errors++;
            $display("FAIL good_wv: got %b want 1", wv_seen);
        end
        checks++;
        if (dout !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL good_data: got %h want a5a50001", dout);
        end
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL good_perr: got %b want 0", perr);
        end
        checks++;
        if (cyc != 34) begin
            errors++;
            $display("FAIL good_latency: got %0d want 34", cyc);
        end
        @(negedge clk);
        checks++;
        if ({word_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL good_pulse_end: got %b want 00", {word_valid, busy});
        end
    endtask

    task automatic test_bad_word;
        run_word(32'hA5A5_0001, 1'b0, 0, -1, 0);
        checks++;
        if (wv_seen !== 1'b1 || perr !== 1'b1) begin
            errors++;
            $display("FAIL bad_perr: got wv=%b perr=%b want 1 1", wv_seen, perr);
        end
`ifdef PARITY_ERR_COUNT_EN
        checks++;
        if (err_count !== 16'h0) begin
            errors++;
            $display("FAIL bad_cnt_before: got %h want 0", err_count);
        end
`endif
        @(negedge clk);
`ifdef PARITY_ERR_COUNT_EN
        checks++;
        if (err_count !== 16'h1) begin
            errors++;
            $display("FAIL bad_cnt_after: got %h want 1", err_count);
        end
`endif
        bit_valid = 1'b1;
        serial_in = 1'b0;
        repeat (5) @(negedge clk);
        bit_valid = 1'b0;
        checks++;
        if (data_out !== 32'hA5A5_0001 || parity_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_hold: got %h/%b want a5a50001/1",
                     data_out, parity_err);
        end
    endtask

    task automatic test_gaps;
        run_word(32'hFFFF_FFFF, 1'b0, 1, -1, 0);
        checks++;
        if (early) begin
            errors++;
            $display("FAIL gaps_early_wv: got early pulse want none");
        end
        checks++;
        if (wv_seen !== 1'b1 || dout !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL gaps_data: got wv=%b %h want 1 ffffffff",
                     wv_seen, dout);
        end
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL gaps_perr: got %b want 0", perr);
        end
        checks++;
        if (cyc != 50) begin
            errors++;
            $display("FAIL gaps_latency: got %0d want 50", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit stray;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_valid = 1'b1;
            serial_in = 1'b1;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, word_valid, parity_err} !== 3'b000 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got busy=%b wv=%b pe=%b d=%h want 0",
                     busy, word_valid, parity_err, data_out);
        end
`ifdef PARITY_ERR_COUNT_EN
        checks++;
        if (err_count !== 16'h0) begin
            errors++;
            $display("FAIL midrst_errcnt: got %h want 0", err_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            bit_valid = 1'b1;
            serial_in = i[0];
            @(negedge clk);
            if (word_valid || busy) stray = 1;
        end
        bit_valid = 1'b0;
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL midrst_partial: got activity want idle");
        end
        run_word(32'h1234_5678, 1'b1, 0, -1, 0);
        checks++;
        if (wv_seen !== 1'b1 || dout !== 32'h1234_5678 || perr !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next: got %b %h %b want 1 12345678 0",
                     wv_seen, dout, perr);
        end
        @(negedge clk);
    endtask

    task automatic test_start_in_data;
        run_word(32'h0F0F_00F0, 1'b0, 0, 5, 0);
        checks++;
        if (wv_seen !== 1'b1 || dout !== 32'h0F0F_00F0 || perr !== 1'b0) begin
            errors++;
            $display("FAIL restart_ignored: got %b %h %b want 1 0f0f00f0 0",
                     wv_seen, dout, perr);
        end
        checks++;
        if (cyc != 34 || early) begin
            errors++;
            $display("FAIL restart_latency: got %0d early=%0b want 34 0",
                     cyc, early);
        end
        @(negedge clk);
    endtask

    task automatic test_start_with_bit;
        run_word(32'h1234_5678, 1'b1, 0, -1, 1);
        checks++;
        if (wv_seen !== 1'b1 || dout !== 32'h1234_5678 || perr !== 1'b0) begin
            errors++;
            $display("FAIL start_bv: got %b %h %b want 1 12345678 0",
                     wv_seen, dout, perr);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] wl [3];
        logic        pl [3];
        logic        el [3];
        wl[0] = 32'hA5A5_0001; pl[0] = 1'b1; el[0] = 1'b0;
        wl[1] = 32'hFFFF_0000; pl[1] = 1'b0; el[1] = 1'b0;
        wl[2] = 32'h8000_0000; pl[2] = 1'b0; el[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_word(wl[k], pl[k], 0, -1, 0);
            checks++;
            if (wv_seen !== 1'b1 || dout !== wl[k] || perr !== el[k]) begin
                errors++;
                $display("FAIL b2b_%0d: got %b %h %b want 1 %h %b",
                         k, wv_seen, dout, perr, wl[k], el[k]);
            end
            @(negedge clk);
        end
    endtask

`ifdef PARITY_ERR_COUNT_EN
    task automatic test_err_counter;
        dut.u_err_counter.count = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            run_word(32'h0000_0003, 1'b1, 0, -1, 0);
            @(negedge clk);
        end
        checks++;
        if (err_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h want ffff", err_count);
        end
        run_word(32'h0000_0003, 1'b1, 0, -1, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_count !== 16'h0) begin
            errors++;
            $display("FAIL cnt_clear_prio: got %h want 0", err_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_word();
        test_bad_word();
        test_gaps();
        test_reset_mid();
        test_start_in_data();
        test_start_with_bit();
        test_back_to_back();
`ifdef PARITY_ERR_COUNT_EN
        test_err_counter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_serial_rx.md
PARITY_SERIAL_RX -- requirements
Module: parity_serial_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the number of payload bits per word (range 2..64).
REQ-002 SHALL have parameter ODD_PARITY, default 0, meaning 0 = even parity and 1 = odd parity.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, which begins word reception when the block is IDLE.
REQ-006 SHALL have port bit_valid, input, 1, which qualifies serial_in on the current clock edge.
REQ-007 SHALL have port serial_in, input, 1, the serial data bit: payload LSB first, then the parity bit.
REQ-008 SHALL have port err_clr, input, 1, a synchronous clear of err_count.
REQ-009 SHALL have port data_out, output, DATA_W, the assembled payload word.
REQ-010 SHALL have port word_valid, output, 1, a one-cycle pulse that qualifies data_out and parity_err.
REQ-011 SHALL have port parity_err, output, 1, high when the received parity mismatches the payload; valid with word_valid.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port err_count, output, 16, the count of parity errors; present only under the configuration macro.

Function
REQ-014 SHALL implement the FSM states IDLE, DATA, PARITY and DONE.
REQ-015 SHALL transition IDLE->DATA on start=1; the bit counter and running parity are cleared on the same edge.
REQ-016 SHALL, in DATA, shift serial_in into data_out[bit_cnt] on each bit_valid=1 edge; bit_valid=0 holds all state.
REQ-017 SHALL transition DATA->PARITY on the edge that accepts payload bit DATA_W-1.
REQ-018 SHALL, in PARITY, capture serial_in on bit_valid=1 and transition to DONE.
REQ-019 SHALL compute parity_err = (XOR of all DATA_W payload bits) ^ parity_bit ^ ODD_PARITY.
REQ-020 SHALL accumulate the payload XOR incrementally, one bit per accepted bit, with no DATA_W-wide XOR tree.
REQ-021 SHALL assert word_valid for exactly one cycle while in DONE, one cycle after the parity bit is accepted, and then transition DONE->IDLE.
REQ-022 SHALL hold data_out stable from DONE until the next start is accepted.
REQ-023 SHALL hold parity_err from DONE until the next start is accepted.
REQ-024 SHALL ignore start outside IDLE (no restart and no error).
REQ-025 SHALL give a start and bit_valid asserted together in IDLE no effect on the shift; the first payload bit is taken on a later edge.
REQ-026 SHALL support back-to-back words: start may be asserted in the cycle after DONE.

Reset
REQ-027 SHALL, on rst=1 at any time including mid-word, immediately force state=IDLE, data_out=0, word_valid=0, parity_err=0, busy=0, the bit counter to 0, the running parity to 0 and err_count=0.
REQ-028 SHALL report no partial word after reset is released.

Configuration
REQ-029 SHALL include, when macro PARITY_ERR_COUNT_EN is defined, the err_count port and a 16-bit counter that increments on each word_valid with parity_err=1.
REQ-030 SHALL saturate the counter at 16'hFFFF.
REQ-031 SHALL set the counter to 0 on err_clr=1, taking priority over a simultaneous increment.
REQ-032 SHALL, when PARITY_ERR_COUNT_EN is undefined, omit the err_count port and counter logic entirely; all other behaviour is identical.

Structure
REQ-033 SHALL place the FSM state enum typedef (rx_state_t) and the constant ERR_CNT_W=16 in shared package parity_pkg.
REQ-034 SHALL implement the saturating error counter as sub-module parity_err_counter, instantiated only under PARITY_ERR_COUNT_EN.

Verification
REQ-035 SHALL cover: DATA_W=32, even parity; send 32'hA5A5_0001 (parity bit 1, total ones even) -> word_valid one pulse, data_out=32'hA5A5_0001, parity_err=0.
REQ-036 SHALL cover: the same word with parity bit 0 -> parity_err=1 and err_count increments 0->1.
REQ-037 SHALL cover: bit_valid toggled 1-0-0-1 randomly across the word 32'hFFFF_FFFF with parity 0 -> data_out=32'hFFFF_FFFF, parity_err=0, latency counted only on valid bits.
REQ-038 SHALL cover: rst asserted after 10 payload bits -> busy=0 and outputs zero immediately, no word_valid; a following full word is received correctly.
REQ-039 SHALL cover: start pulsed during DATA -> ignored and the word completes unchanged.
REQ-040 SHALL cover: err_count preloaded to 16'hFFFE then 3 error words -> 16'hFFFF holds; err_clr together with an error word -> err_count=0.
